// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller driving one external 1-bit full adder, LSB first.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the operation into a-b.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             fa_x,
    output logic             fa_y,
    output logic             fa_z,
    input  logic             fa_sum,
    input  logic             fa_cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so the carry seed is forced to 1 and cin is ignored
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub | cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // The shared full adder only sees live operands while running; it is quiet otherwise
    assign fa_x = (state == RUN) & a_sh[0];
    assign fa_y = (state == RUN) & b_sh[0];
    assign fa_z = (state == RUN) & carry;

    // Controller: capture operands, shift one bit per clock, publish result on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b_load;
                        carry  <= carry_load;
                        cnt    <= '0;
                        sum_sh <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= {fa_sum, sum_sh[WIDTH-1:1]};
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed bench with a scoreboard of expected {cout,sum} per accepted start.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         busy, done, cout, fa_x, fa_y, fa_z, fa_sum, fa_cout;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [W:0] exp_q[$];

    // External combinational full adder
    assign fa_sum  = fa_x ^ fa_y ^ fa_z;
    assign fa_cout = (fa_x & fa_y) | (fa_z & (fa_x ^ fa_y));

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout),
        .fa_x(fa_x), .fa_y(fa_y), .fa_z(fa_z), .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done_cnt), 32'(0));
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("sb_sum", 32'(sum), 32'(e[W-1:0]));
                check("sb_cout", 32'(cout), 32'(e[W]));
            end
        end
    end

    // One operation with per-bit checks of the full-adder drive; poke>=0 re-pulses start in RUN
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          input logic sv, input int poke);
        logic [W-1:0] be;
        logic         c;
        logic [W:0]   res;
        be  = sv ? ~bv : bv;
        c   = sv ? 1'b1 : cv;
        res = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, c};
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = cv;
`ifdef SERIAL_ADDER_SUB_EN
        sub = sv;
`endif
        exp_q.push_back(res);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            if (k == poke) begin start = 1'b1; a = 8'h01; b = 8'h01; end
            if (k == poke + 1) start = 1'b0;
            check("run_busy", 32'(busy), 32'(1));
            check("run_done", 32'(done), 32'(0));
            check("fa_x", 32'(fa_x), 32'(av[k]));
            check("fa_y", 32'(fa_y), 32'(be[k]));
            check("fa_z", 32'(fa_z), 32'(c));
            c = (av[k] & be[k]) | (c & (av[k] ^ be[k]));
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", 32'(done), 32'(1));
        check("busy_at_done", 32'(busy), 32'(0));
        check("fa_z_at_done", 32'(fa_z), 32'(0));
        @(negedge clk);
        check("done_cleared", 32'(done), 32'(0));
        check("sum_held", 32'(sum), 32'(res[W-1:0]));
        check("cout_held", 32'(cout), 32'(res[W]));
    endtask

    initial begin
        int n;
        int d0;
        #1;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        check("rst_fa", 32'({fa_x, fa_y, fa_z}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, -1);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, -1);
        run_op(8'h00, 8'h00, 1'b0, 1'b0, -1);

        d0 = done_cnt;
        run_op(8'h40, 8'h05, 1'b0, 1'b0, 3);
        repeat (4) @(negedge clk);
        check("ignored_start_one_done", 32'(done_cnt), 32'(d0 + 1));
        check("ignored_start_idle", 32'(busy), 32'(0));

        check("sum_before_abort", 32'(sum), 32'(8'h45));
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_pre_busy", 32'(busy), 32'(1));
        check("abort_pre_fa", 32'({fa_x, fa_y, fa_z}), 32'(3'b111));
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_sum", 32'(sum), 32'(0));
        check("abort_cout", 32'(cout), 32'(0));
        check("abort_fa", 32'({fa_x, fa_y, fa_z}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_idle", 32'(busy), 32'(0));
        run_op(8'h12, 8'h34, 1'b0, 1'b0, -1);

        @(negedge clk);
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
        for (int op = 0; op < 3; op++) begin
            exp_q.push_back({1'b1, 8'h00});
            for (n = 1; n <= 30; n++) begin
                @(negedge clk);
                if (done) break;
            end
            check("b2b_interval", 32'(n), 32'(op == 0 ? W + 1 : W + 2));
            if (op == 2) start = 1'b0;
        end
        repeat (4) @(negedge clk);
        check("b2b_stopped", 32'(busy), 32'(0));

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, -1);
        check("sub_10_01", 32'({cout, sum}), 32'({1'b1, 8'h0F}));
        run_op(8'h01, 8'h02, 1'b1, 1'b1, -1);
        check("sub_01_02", 32'({cout, sum}), 32'({1'b0, 8'hFF}));
        run_op(8'h33, 8'h11, 1'b0, 1'b0, -1);
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
